// File: rtl/wb_fabric_pkg.sv
// Shared types and constants for the Wishbone fabric decoder.
package wb_fabric_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_TERM,
        ST_DONE
    } fab_state_e;

    localparam logic [31:0] FABRIC_DEFAULT_READ = 32'hBAD_FAB_AC;
    localparam int unsigned ERR_CNT_WIDTH       = 8;

endpackage

// File: rtl/wb_fabric_watchdog.sv
// Bus watchdog: counts cycles of an outstanding access and flags expiry.
module wb_fabric_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 15,
    parameter int unsigned TIMEOUT_WIDTH  = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired_c
);

    logic [TIMEOUT_WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + TIMEOUT_WIDTH'(1);
        end
    end

    // Count equals the cycle index of the access, so expiry marks the last cycle an ACK may win.
    assign expired_c = (count == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/wb_fabric_decoder.sv
// Wishbone fabric decoder: aperture decode, ACK/data mux and bus watchdog with error capture.
module wb_fabric_decoder
    import wb_fabric_pkg::*;
#(
    parameter int unsigned NUM_SLAVES         = 4,
    parameter int unsigned APERWIDTH          = 17,
    parameter int unsigned APERSIZE           = 10,
    parameter logic [NUM_SLAVES*APERWIDTH-1:0] BASE_ADDR =
        {17'h05000, 17'h04000, 17'h01000, 17'h00000},
    parameter int unsigned TIMEOUT_CYCLES     = 15,
    parameter int unsigned TIMEOUT_WIDTH      = 4,
    parameter logic [31:0] DEFAULT_READ_VALUE = FABRIC_DEFAULT_READ
) (
    input  logic                       WBs_CLK_i,
    input  logic                       WBs_RST_n_i,
    input  logic [APERWIDTH-1:0]       WBs_ADR_i,
    input  logic                       WBs_CYC_i,
    input  logic                       WBs_STB_i,
    input  logic                       WBs_WE_i,
    output logic [31:0]                WBs_DAT_o,
    output logic                       WBs_ACK_o,
    output logic [NUM_SLAVES-1:0]      Slv_CYC_o,
    input  logic [NUM_SLAVES*32-1:0]   Slv_DAT_i,
    input  logic [NUM_SLAVES-1:0]      Slv_ACK_i,
    input  logic                       Err_Clr_i,
    output logic                       Err_Intr_o,
    output logic [APERWIDTH-1:0]       Err_ADR_o,
    output logic                       Err_WE_o,
    output logic [ERR_CNT_WIDTH-1:0]   Err_Cnt_o
);

    localparam int unsigned DEC_LSB = APERSIZE + 2;
    localparam int unsigned DEC_W   = APERWIDTH - DEC_LSB;

    fab_state_e                 state;
    logic [NUM_SLAVES-1:0]      match;
    logic [NUM_SLAVES-1:0]      hit;
    logic                       any_hit;
    logic                       sel_ack;
    logic [31:0]                sel_dat;
    logic                       access;
    logic                       force_term;
    logic                       pass;
    logic                       wd_en;
    logic                       expired;
    logic                       err_intr;
    logic [APERWIDTH-1:0]       err_adr;
    logic                       err_we;
    logic [ERR_CNT_WIDTH-1:0]   err_cnt;

    // Aperture decode; lowest matching index wins on overlap.
    always_comb begin
        match   = '0;
        sel_dat = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            match[i] = (WBs_ADR_i[APERWIDTH-1:DEC_LSB] ==
                        BASE_ADDR[i*APERWIDTH+DEC_LSB +: DEC_W]);
        end
        hit     = match & (~match + NUM_SLAVES'(1));
        any_hit = |match;
        sel_ack = |(hit & Slv_ACK_i);
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (hit[i]) begin
                sel_dat = Slv_DAT_i[i*32 +: 32];
            end
        end
    end

    assign access     = WBs_CYC_i & WBs_STB_i;
    assign force_term = (state == ST_TERM);
    assign pass       = access & any_hit & ((state == ST_IDLE) | (state == ST_WAIT));
    assign wd_en      = (state == ST_WAIT) | ((state == ST_IDLE) & access);

    assign WBs_ACK_o  = force_term | (pass & sel_ack);
    assign WBs_DAT_o  = (force_term | ~any_hit) ? DEFAULT_READ_VALUE : sel_dat;
    assign Slv_CYC_o  = hit & {NUM_SLAVES{WBs_CYC_i & ~force_term}};

    wb_fabric_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TIMEOUT_WIDTH  (TIMEOUT_WIDTH)
    ) u_watchdog (
        .clk       (WBs_CLK_i),
        .rst_n     (WBs_RST_n_i),
        .clr       (~wd_en),
        .en        (wd_en),
        .expired_c (expired)
    );

    // Access sequencing and error status; a capture in TERM takes priority over a clear.
    always_ff @(posedge WBs_CLK_i) begin
        if (!WBs_RST_n_i) begin
            state    <= ST_IDLE;
            err_intr <= 1'b0;
            err_adr  <= '0;
            err_we   <= 1'b0;
            err_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (access) begin
                        if (!any_hit) begin
                            state <= ST_TERM;
                        end else if (sel_ack) begin
                            state <= ST_DONE;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!WBs_CYC_i) begin
                        state <= ST_IDLE;
                    end else if (sel_ack) begin
                        state <= ST_DONE;
                    end else if (expired) begin
                        state <= ST_TERM;
                    end
                end
                ST_TERM: state <= ST_DONE;
                ST_DONE: begin
                    if (!WBs_CYC_i) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (force_term) begin
                err_intr <= 1'b1;
                if (!err_intr || Err_Clr_i) begin
                    err_adr <= WBs_ADR_i;
                    err_we  <= WBs_WE_i;
                end
                if (Err_Clr_i) begin
                    err_cnt <= ERR_CNT_WIDTH'(1);
                end else if (err_cnt != '1) begin
                    err_cnt <= err_cnt + ERR_CNT_WIDTH'(1);
                end
            end else if (Err_Clr_i) begin
                err_intr <= 1'b0;
                err_adr  <= '0;
                err_we   <= 1'b0;
                err_cnt  <= '0;
            end
        end
    end

    assign Err_Intr_o = err_intr;
    assign Err_ADR_o  = err_adr;
    assign Err_WE_o   = err_we;
    assign Err_Cnt_o  = err_cnt;

endmodule

// File: tb/tb_wb_fabric_decoder.sv
// Directed self-checking bench for wb_fabric_decoder with default parameters.
module tb_wb_fabric_decoder;

    localparam int unsigned NS  = 4;
    localparam int unsigned AW  = 17;
    localparam logic [31:0] DEF = 32'hBAD_FAB_AC;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [AW-1:0]   adr;
    logic            cyc;
    logic            stb;
    logic            we;
    logic [31:0]     dat_o;
    logic            ack_o;
    logic [NS-1:0]   slv_cyc;
    logic [NS*32-1:0] slv_dat;
    logic [NS-1:0]   slv_ack;
    logic            err_clr;
    logic            err_intr;
    logic [AW-1:0]   err_adr;
    logic            err_we;
    logic [7:0]      err_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wb_fabric_decoder dut (
        .WBs_CLK_i   (clk),
        .WBs_RST_n_i (rst_n),
        .WBs_ADR_i   (adr),
        .WBs_CYC_i   (cyc),
        .WBs_STB_i   (stb),
        .WBs_WE_i    (we),
        .WBs_DAT_o   (dat_o),
        .WBs_ACK_o   (ack_o),
        .Slv_CYC_o   (slv_cyc),
        .Slv_DAT_i   (slv_dat),
        .Slv_ACK_i   (slv_ack),
        .Err_Clr_i   (err_clr),
        .Err_Intr_o  (err_intr),
        .Err_ADR_o   (err_adr),
        .Err_WE_o    (err_we),
        .Err_Cnt_o   (err_cnt)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic start(input logic [AW-1:0] a, input logic w);
        adr = a;
        we  = w;
        cyc = 1'b1;
        stb = 1'b1;
    endtask

    task automatic stop();
        cyc     = 1'b0;
        stb     = 1'b0;
        we      = 1'b0;
        slv_ack = '0;
    endtask

    // Unmapped access: cycle 0 request, cycle 1 TERM ACK, returns in cycle 2 (DONE, CYC low).
    task automatic miss(input logic [AW-1:0] a, input logic w, input logic clr_in_term,
                        input logic chk);
        step();
        start(a, w);
        if (chk) begin
            settle();
            check("miss_c0_ack", 32'(ack_o), 0);
        end
        step();
        err_clr = clr_in_term;
        if (chk) begin
            settle();
            check("miss_c1_ack", 32'(ack_o), 1);
            check("miss_c1_dat", dat_o, DEF);
        end
        step();
        err_clr = 1'b0;
        stop();
    endtask

    task automatic clear_errors();
        step();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL bench_timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst_n   = 1'b0;
        adr     = 17'h02000;
        cyc     = 1'b0;
        stb     = 1'b0;
        we      = 1'b0;
        slv_dat = '0;
        slv_ack = '0;
        err_clr = 1'b0;
        repeat (3) step();
        settle();
        check("rst_ack", 32'(ack_o), 0);
        check("rst_dat", dat_o, DEF);
        check("rst_slv_cyc", 32'(slv_cyc), 0);
        check("rst_intr", 32'(err_intr), 0);
        check("rst_eadr", 32'(err_adr), 0);
        check("rst_ewe", 32'(err_we), 0);
        check("rst_cnt", 32'(err_cnt), 0);
        step();
        rst_n = 1'b1;

        // Slave 2 read, ACK in cycle 3
        step();
        start(17'h04008, 1'b0);
        settle();
        check("s2_c0_cyc", 32'(slv_cyc), 32'h4);
        check("s2_c0_ack", 32'(ack_o), 0);
        for (int c = 1; c < 3; c++) begin
            step();
            settle();
            check("s2_wait_ack", 32'(ack_o), 0);
        end
        step();
        slv_ack = 4'b0100;
        slv_dat[64 +: 32] = 32'h1234_5678;
        settle();
        check("s2_c3_ack", 32'(ack_o), 1);
        check("s2_c3_dat", dat_o, 32'h1234_5678);
        check("s2_c3_cyc", 32'(slv_cyc), 32'h4);
        step();
        stop();
        settle();
        check("s2_done_ack", 32'(ack_o), 0);

        // Unmapped read
        miss(17'h02000, 1'b0, 1'b0, 1'b1);
        settle();
        check("miss_intr", 32'(err_intr), 1);
        check("miss_eadr", 32'(err_adr), 32'h02000);
        check("miss_ewe", 32'(err_we), 0);
        check("miss_cnt", 32'(err_cnt), 1);

        clear_errors();
        settle();
        check("clr_intr", 32'(err_intr), 0);
        check("clr_eadr", 32'(err_adr), 0);
        check("clr_cnt", 32'(err_cnt), 0);

        // Silent slave 0 write: forced ACK in cycle 15, late ACK in cycle 16 ignored
        step();
        start(17'h00010, 1'b1);
        for (int c = 0; c < 15; c++) begin
            if (c != 0) step();
            settle();
            check("wd_no_ack", 32'(ack_o), 0);
        end
        step();
        settle();
        check("wd_c15_ack", 32'(ack_o), 1);
        check("wd_c15_dat", dat_o, DEF);
        check("wd_c15_cyc", 32'(slv_cyc), 0);
        step();
        slv_ack = 4'b0001;
        settle();
        check("wd_late_ack", 32'(ack_o), 0);
        check("wd_intr", 32'(err_intr), 1);
        check("wd_eadr", 32'(err_adr), 32'h00010);
        check("wd_ewe", 32'(err_we), 1);
        check("wd_cnt", 32'(err_cnt), 1);
        step();
        stop();

        // Slave 1 ACK in cycle 14 beats the watchdog
        step();
        start(17'h01020, 1'b0);
        repeat (14) step();
        slv_ack = 4'b0010;
        slv_dat[32 +: 32] = 32'hCAFE_0001;
        settle();
        check("edge_ack", 32'(ack_o), 1);
        check("edge_dat", dat_o, 32'hCAFE_0001);
        step();
        stop();
        settle();
        check("edge_c15_ack", 32'(ack_o), 0);
        check("edge_cnt", 32'(err_cnt), 1);

        // First error held until a clear; capture wins over coincident clear
        clear_errors();
        miss(17'h02000, 1'b0, 1'b0, 1'b0);
        miss(17'h03004, 1'b1, 1'b0, 1'b0);
        settle();
        check("hold_eadr", 32'(err_adr), 32'h02000);
        check("hold_ewe", 32'(err_we), 0);
        check("hold_cnt", 32'(err_cnt), 2);
        miss(17'h07000, 1'b0, 1'b1, 1'b1);
        settle();
        check("clrcap_intr", 32'(err_intr), 1);
        check("clrcap_eadr", 32'(err_adr), 32'h07000);
        check("clrcap_cnt", 32'(err_cnt), 1);

        // Stray ACK from slave 1 during slave 3 access
        step();
        start(17'h05000, 1'b0);
        slv_ack = 4'b0010;
        slv_dat[96 +: 32] = 32'h3333_3333;
        for (int c = 0; c < 4; c++) begin
            if (c != 0) step();
            settle();
            check("stray_ack", 32'(ack_o), 0);
        end
        check("stray_dat", dat_o, 32'h3333_3333);
        step();
        slv_ack = 4'b1010;
        settle();
        check("s3_ack", 32'(ack_o), 1);
        check("s3_dat", dat_o, 32'h3333_3333);
        step();
        stop();

        // Master drops CYC in WAIT: no ACK, no error, FSM idle again
        step();
        start(17'h01000, 1'b0);
        step();
        step();
        stop();
        settle();
        check("drop_ack", 32'(ack_o), 0);
        repeat (20) step();
        settle();
        check("drop_cnt", 32'(err_cnt), 1);
        check("drop_idle_ack", 32'(ack_o), 0);
        step();
        start(17'h01000, 1'b0);
        slv_ack = 4'b0010;
        settle();
        check("drop_next_ack", 32'(ack_o), 1);
        step();
        stop();

        // Reset asserted in WAIT
        step();
        start(17'h04000, 1'b0);
        step();
        step();
        rst_n = 1'b0;
        step();
        settle();
        check("rstw_ack", 32'(ack_o), 0);
        check("rstw_intr", 32'(err_intr), 0);
        check("rstw_eadr", 32'(err_adr), 0);
        check("rstw_ewe", 32'(err_we), 0);
        check("rstw_cnt", 32'(err_cnt), 0);
        stop();
        adr = 17'h02000;
        settle();
        check("rstw_dat", dat_o, DEF);
        check("rstw_slv_cyc", 32'(slv_cyc), 0);
        step();
        rst_n = 1'b1;
        step();
        start(17'h04000, 1'b0);
        slv_ack = 4'b0100;
        slv_dat[64 +: 32] = 32'h5A5A_A5A5;
        settle();
        check("post_rst_ack", 32'(ack_o), 1);
        check("post_rst_dat", dat_o, 32'h5A5A_A5A5);
        step();
        stop();

        // Error counter saturation
        for (int n = 0; n < 255; n++) miss(17'h02000, 1'b0, 1'b0, 1'b0);
        settle();
        check("sat_cnt_255", 32'(err_cnt), 255);
        miss(17'h07000, 1'b1, 1'b0, 1'b0);
        settle();
        check("sat_cnt_256", 32'(err_cnt), 255);
        check("sat_eadr", 32'(err_adr), 32'h02000);
        check("sat_intr", 32'(err_intr), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
